// File: rtl/sketch_readout.sv
// ============================================================================
//  Module   : sketch_readout
//  Brief    : Snapshots the bottom-k sorter index array at frame end and
//             streams it smallest-first over valid/ready, then clears the sorter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sketch_readout #(
    parameter int INDEX_WIDTH     = 10,
    parameter int NUM_COMPARATORS = 8,
    parameter int LOG_COMPARATORS = 3,
    parameter int FRAME_ID_WIDTH  = 8
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [NUM_COMPARATORS*INDEX_WIDTH-1:0]   indices_flat,
    input  logic                                     frame_done,
    input  logic [INDEX_WIDTH:0]                     frame_len,
    output logic                                     sorter_clear,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [INDEX_WIDTH-1:0]                   out_index,
    output logic [LOG_COMPARATORS-1:0]               out_rank,
    output logic [FRAME_ID_WIDTH-1:0]                out_frame_id,
    output logic                                     out_last,
    output logic                                     busy,
    output logic                                     drop_err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [INDEX_WIDTH:0]       NC_LEN   = (INDEX_WIDTH+1)'(NUM_COMPARATORS);
    localparam logic [LOG_COMPARATORS:0]   N_MAX    = (LOG_COMPARATORS+1)'(NUM_COMPARATORS);
    localparam logic [LOG_COMPARATORS:0]   N_ONE    = (LOG_COMPARATORS+1)'(1);
    localparam logic [LOG_COMPARATORS-1:0] RANK_ONE = LOG_COMPARATORS'(1);
    localparam logic [FRAME_ID_WIDTH-1:0]  FID_ONE  = FRAME_ID_WIDTH'(1);

    state_t                       state_q, state_d;
    logic [INDEX_WIDTH-1:0]       snap_q [NUM_COMPARATORS];
    logic [INDEX_WIDTH-1:0]       snap_d [NUM_COMPARATORS];
    logic [LOG_COMPARATORS:0]     n_q, n_d;
    logic [LOG_COMPARATORS-1:0]   rank_q, rank_d;
    logic [FRAME_ID_WIDTH-1:0]    frame_id_q, frame_id_d;
    logic [FRAME_ID_WIDTH-1:0]    frame_cnt_q, frame_cnt_d;
    logic                         clear_q, clear_d;
    logic                         drop_q, drop_d;

    logic                         is_send;
    logic                         last_beat;
    logic                         xfer;
    logic                         accept;
    logic [LOG_COMPARATORS:0]     len_clamped;

    assign is_send     = (state_q == SEND);
    assign last_beat   = is_send && ({1'b0, rank_q} == (n_q - N_ONE));
    assign xfer        = is_send && out_ready;
    // A new frame may land on the very edge the previous frame's last beat leaves.
    assign accept      = frame_done && (!is_send || (xfer && last_beat));
    assign len_clamped = (frame_len > NC_LEN) ? N_MAX : frame_len[LOG_COMPARATORS:0];

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        rank_d      = rank_q;
        frame_id_d  = frame_id_q;
        frame_cnt_d = frame_cnt_q;
        clear_d     = 1'b0;
        drop_d      = drop_q;
        for (int r = 0; r < NUM_COMPARATORS; r++) begin
            snap_d[r] = snap_q[r];
        end

        if (xfer) begin
            rank_d = rank_q + RANK_ONE;
            if (last_beat) begin
                state_d = IDLE;
            end
        end

        if (accept) begin
            for (int r = 0; r < NUM_COMPARATORS; r++) begin
                snap_d[r] = indices_flat[r*INDEX_WIDTH +: INDEX_WIDTH];
            end
            n_d         = len_clamped;
            rank_d      = '0;
            frame_id_d  = frame_cnt_q;
            frame_cnt_d = frame_cnt_q + FID_ONE;
            clear_d     = 1'b1;
            state_d     = (len_clamped != '0) ? SEND : IDLE;
        end else if (frame_done) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            rank_q      <= '0;
            frame_id_q  <= '0;
            frame_cnt_q <= '0;
            clear_q     <= 1'b0;
            drop_q      <= 1'b0;
            for (int r = 0; r < NUM_COMPARATORS; r++) begin
                snap_q[r] <= '0;
            end
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            rank_q      <= rank_d;
            frame_id_q  <= frame_id_d;
            frame_cnt_q <= frame_cnt_d;
            clear_q     <= clear_d;
            drop_q      <= drop_d;
            for (int r = 0; r < NUM_COMPARATORS; r++) begin
                snap_q[r] <= snap_d[r];
            end
        end
    end

    // Beat fields are forced to zero outside SEND so the bus is quiet when idle.
    assign out_valid    = is_send;
    assign out_index    = is_send ? snap_q[rank_q] : '0;
    assign out_rank     = is_send ? rank_q : '0;
    assign out_frame_id = is_send ? frame_id_q : '0;
    assign out_last     = last_beat;
    assign busy         = is_send;
    assign sorter_clear = clear_q;
    assign drop_err     = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_sketch_readout.sv
// ============================================================================
//  Module   : tb_sketch_readout
//  Brief    : Scoreboard bench for sketch_readout: beats expected at frame
//             acceptance are compared in order as they leave the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sketch_readout;

    localparam int IW = 10;
    localparam int NC = 8;
    localparam int LC = 3;
    localparam int FW = 8;

    logic               clock;
    logic               reset;
    logic [NC*IW-1:0]   indices_flat;
    logic               frame_done;
    logic [IW:0]        frame_len;
    logic               sorter_clear;
    logic               out_valid;
    logic               out_ready;
    logic [IW-1:0]      out_index;
    logic [LC-1:0]      out_rank;
    logic [FW-1:0]      out_frame_id;
    logic               out_last;
    logic               busy;
    logic               drop_err;

    sketch_readout #(
        .INDEX_WIDTH     (IW),
        .NUM_COMPARATORS (NC),
        .LOG_COMPARATORS (LC),
        .FRAME_ID_WIDTH  (FW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .indices_flat (indices_flat),
        .frame_done   (frame_done),
        .frame_len    (frame_len),
        .sorter_clear (sorter_clear),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_index    (out_index),
        .out_rank     (out_rank),
        .out_frame_id (out_frame_id),
        .out_last     (out_last),
        .busy         (busy),
        .drop_err     (drop_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [IW-1:0] idx;
        logic [LC-1:0] rank;
        logic [FW-1:0] fid;
        logic          last;
    } beat_t;

    beat_t       sb[$];
    logic [FW-1:0] exp_fid;
    int          checks;
    int          errors;
    int          beat_count;

    // Monitor: pops one expected beat per handshake and checks stall stability.
    beat_t         mon_exp;
    logic          stall_prev;
    logic [IW-1:0] s_idx;
    logic [LC-1:0] s_rank;
    logic [FW-1:0] s_fid;
    logic          s_last;

    always @(negedge clock) begin
        if (!reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_index !== s_idx || out_rank !== s_rank ||
                    out_frame_id !== s_fid || out_last !== s_last) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b idx=%0d rank=%0d fid=%0d last=%0b, want v=1 idx=%0d rank=%0d fid=%0d last=%0b",
                             out_valid, out_index, out_rank, out_frame_id, out_last, s_idx, s_rank, s_fid, s_last);
                end
            end
            if (out_valid && out_ready) begin
                beat_count++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got idx=%0d rank=%0d fid=%0d, want no beat",
                             out_index, out_rank, out_frame_id);
                end else begin
                    mon_exp = sb.pop_front();
                    if (out_index !== mon_exp.idx || out_rank !== mon_exp.rank ||
                        out_frame_id !== mon_exp.fid || out_last !== mon_exp.last) begin
                        errors++;
                        $display("FAIL beat: got idx=%0d rank=%0d fid=%0d last=%0b, want idx=%0d rank=%0d fid=%0d last=%0b",
                                 out_index, out_rank, out_frame_id, out_last,
                                 mon_exp.idx, mon_exp.rank, mon_exp.fid, mon_exp.last);
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            s_idx  = out_index;
            s_rank = out_rank;
            s_fid  = out_frame_id;
            s_last = out_last;
        end
    end

    // Drives one frame_done pulse; when acc is set the frame's beats are queued.
    task automatic pulse_frame(input logic [NC*IW-1:0] flat, input logic [IW:0] len, input bit acc);
        int n;
        beat_t b;
        indices_flat = flat;
        frame_len    = len;
        frame_done   = 1'b1;
        if (acc) begin
            n = (len > NC) ? NC : int'(len);
            for (int r = 0; r < n; r++) begin
                b.idx  = flat[r*IW +: IW];
                b.rank = LC'(r);
                b.fid  = exp_fid;
                b.last = (r == n - 1);
                sb.push_back(b);
            end
            exp_fid = exp_fid + 8'd1;
        end
        @(posedge clock);
        #1;
        frame_done = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset        = 1'b0;
        indices_flat = '0;
        frame_done   = 1'b0;
        frame_len    = '0;
        out_ready    = 1'b1;
        exp_fid      = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({sorter_clear, out_valid, out_index, out_rank, out_frame_id, out_last, busy, drop_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got clr=%0b v=%0b idx=%0d rank=%0d fid=%0d last=%0b busy=%0b drop=%0b, want all 0",
                     sorter_clear, out_valid, out_index, out_rank, out_frame_id, out_last, busy, drop_err);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_basic;
        logic [NC*IW-1:0] flat;
        for (int r = 0; r < NC; r++) flat[r*IW +: IW] = IW'(r + 1);
        pulse_frame(flat, 11'd9, 1'b1);
        @(negedge clock);
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_rank !== LC'(i) || out_last !== (i == NC - 1) ||
                sorter_clear !== (i == 0)) begin
                errors++;
                $display("FAIL basic_cycle%0d: got v=%0b rank=%0d last=%0b clr=%0b, want v=1 rank=%0d last=%0b clr=%0b",
                         i, out_valid, out_rank, out_last, sorter_clear, i, (i == NC - 1), (i == 0));
            end
            @(negedge clock);
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: got busy=%0b v=%0b, want busy=0 v=0", busy, out_valid);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_short;
        logic [NC*IW-1:0] flat;
        bit ok;
        int base;
        for (int r = 0; r < NC; r++) flat[r*IW +: IW] = IW'(11 + r);
        flat[0*IW +: IW] = 10'd4;
        flat[1*IW +: IW] = 10'd2;
        flat[2*IW +: IW] = 10'd7;
        base = beat_count;
        pulse_frame(flat, 11'd3, 1'b1);
        wait_drain(ok);
        checks++;
        if (!ok || beat_count - base != 3) begin
            errors++;
            $display("FAIL short_beats: got %0d beats drained=%0b, want 3 beats drained=1", beat_count - base, ok);
        end
        base = beat_count;
        pulse_frame(flat, 11'd0, 1'b1);
        @(negedge clock);
        checks++;
        if (sorter_clear !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len: got clr=%0b v=%0b busy=%0b, want clr=1 v=0 busy=0", sorter_clear, out_valid, busy);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (beat_count != base) begin
            errors++;
            $display("FAIL zero_len_beats: got %0d beats, want 0", beat_count - base);
        end
        @(posedge clock);
        #1;
        flat[0*IW +: IW] = 10'd99;
        pulse_frame(flat, 11'd2, 1'b1);
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL short_fid2_drain: got drained=0, want drained=1");
        end
    endtask

    task automatic test_backpressure;
        logic [NC*IW-1:0] flat;
        logic [3:0] pattern;
        int base;
        pattern = 4'b1001;
        for (int r = 0; r < NC; r++) flat[r*IW +: IW] = IW'(100 + 17 * r);
        base = beat_count;
        pulse_frame(flat, 11'd8, 1'b1);
        for (int c = 0; c < 200; c++) begin
            out_ready = pattern[c % 4];
            if (c == 3 || c == 9) indices_flat = {$urandom, $urandom, $urandom};
            @(posedge clock);
            #1;
            if (beat_count - base >= 8 && !busy) break;
        end
        out_ready = 1'b1;
        checks++;
        if (beat_count - base != 8 || sb.size() != 0) begin
            errors++;
            $display("FAIL backpressure_beats: got %0d beats pending=%0d, want 8 beats pending=0",
                     beat_count - base, sb.size());
        end
    endtask

    task automatic test_back_to_back_drop;
        logic [NC*IW-1:0] fa, fb, fd, fc;
        bit ok;
        for (int r = 0; r < NC; r++) begin
            fa[r*IW +: IW] = IW'(21 + r);
            fb[r*IW +: IW] = IW'(31 + r);
            fd[r*IW +: IW] = 10'h3ff;
            fc[r*IW +: IW] = IW'(500 + r);
        end
        pulse_frame(fa, 11'd4, 1'b1);
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (out_rank !== 3'd3 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_last_beat: got rank=%0d last=%0b, want rank=3 last=1", out_rank, out_last);
        end
        pulse_frame(fb, 11'd8, 1'b1);
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_rank !== 3'd0 || sorter_clear !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_gap: got v=%0b rank=%0d clr=%0b, want v=1 rank=0 clr=1", out_valid, out_rank, sorter_clear);
        end
        @(posedge clock);
        #1;
        pulse_frame(fd, 11'd5, 1'b0);
        @(negedge clock);
        checks++;
        if (sorter_clear !== 1'b0 || drop_err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drop: got clr=%0b drop=%0b busy=%0b, want clr=0 drop=1 busy=1", sorter_clear, drop_err, busy);
        end
        @(posedge clock);
        #1;
        wait_drain(ok);
        pulse_frame(fc, 11'd1, 1'b1);
        wait_drain(ok);
        checks++;
        if (!ok || drop_err !== 1'b1) begin
            errors++;
            $display("FAIL drop_sticky: got drained=%0b drop=%0b, want drained=1 drop=1", ok, drop_err);
        end
    endtask

    task automatic test_reset_mid_send;
        logic [NC*IW-1:0] flat;
        int base;
        for (int r = 0; r < NC; r++) flat[r*IW +: IW] = IW'(700 + r);
        pulse_frame(flat, 11'd8, 1'b1);
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({sorter_clear, out_valid, out_index, out_rank, out_frame_id, out_last, busy, drop_err} !== '0) begin
            errors++;
            $display("FAIL async_reset: got clr=%0b v=%0b idx=%0d rank=%0d fid=%0d last=%0b busy=%0b drop=%0b, want all 0",
                     sorter_clear, out_valid, out_index, out_rank, out_frame_id, out_last, busy, drop_err);
        end
        sb.delete();
        exp_fid = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        base = beat_count;
        repeat (4) @(negedge clock);
        checks++;
        if (beat_count != base || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_abandon: got %0d beats v=%0b, want 0 beats v=0", beat_count - base, out_valid);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_wrap;
        logic [NC*IW-1:0] flat;
        bit ok;
        int base;
        flat = '0;
        base = beat_count;
        for (int f = 0; f < 257; f++) begin
            flat[0 +: IW] = IW'(f);
            pulse_frame(flat, 11'd1, 1'b1);
        end
        wait_drain(ok);
        checks++;
        if (!ok || beat_count - base != 257) begin
            errors++;
            $display("FAIL wrap_frames: got %0d beats drained=%0b, want 257 drained=1", beat_count - base, ok);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        beat_count = 0;
        stall_prev = 1'b0;
        test_reset();
        test_basic();
        test_short();
        test_backpressure();
        test_back_to_back_drop();
        test_reset_mid_send();
        test_wrap();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover_beats: got %0d pending, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
